// File: rtl/timer_irq_peripheral.sv
// Memory-mapped reload timer with prescaler, free-running cycle counter and a
// level interrupt request derived from the next-state enable/status bits.
module timer_irq_peripheral #(
   parameter logic [31:0] ADDR_BASE = 32'h40000000,
   parameter int unsigned PRESCALE  = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        MemRd,
   input  logic        MemWr,
   input  logic [31:0] Addr,
   input  logic [31:0] WriteData,
   output logic [31:0] ReadData,
   output logic        IRQ
);
   localparam logic [15:0] PCNT_LAST = 16'(PRESCALE - 1);

   logic [31:0] th_reg, th_next;
   logic [31:0] tl_reg, tl_next;
   logic [31:0] systick_reg;
   logic [15:0] pcnt_reg, pcnt_next;
   logic        en_reg, en_next;
   logic        ie_reg, ie_next;
   logic        is_reg, is_next;
   logic        irq_reg;

   logic        hit;
   logic [2:0]  sel;
   logic        wr_th, wr_tl, wr_tcon;
   logic        tick, ovf;
   logic        unused_addr_lsbs;

   assign unused_addr_lsbs = &{1'b0, Addr[1:0]};

   assign sel     = Addr[4:2];
   assign hit     = (Addr[31:5] == ADDR_BASE[31:5]) && (sel <= 3'd5);
   assign wr_th   = MemWr && hit && (sel == 3'd0);
   assign wr_tl   = MemWr && hit && (sel == 3'd1);
   assign wr_tcon = MemWr && hit && (sel == 3'd2);

   // A software TL write swallows a coincident tick, so it cannot overflow.
   assign tick = en_reg && (pcnt_reg == PCNT_LAST);
   assign ovf  = tick && !wr_tl && (tl_reg == 32'hFFFF_FFFF);

   always_comb begin
      pcnt_next = pcnt_reg;
      if (wr_tcon && !WriteData[0]) begin
         pcnt_next = 16'h0;
      end else if (tick) begin
         pcnt_next = 16'h0;
      end else if (en_reg) begin
         pcnt_next = pcnt_reg + 16'h1;
      end
   end

   always_comb begin
      tl_next = tl_reg;
      if (wr_tl) begin
         tl_next = WriteData;
      end else if (ovf) begin
         tl_next = th_reg;
      end else if (tick) begin
         tl_next = tl_reg + 32'h1;
      end
   end

   // Overflow-driven set of IS wins over a simultaneous software clear.
   always_comb begin
      th_next = wr_th ? WriteData : th_reg;
      en_next = wr_tcon ? WriteData[0] : en_reg;
      ie_next = wr_tcon ? WriteData[1] : ie_reg;
      is_next = (wr_tcon ? WriteData[2] : is_reg) | (ovf & ie_reg);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         th_reg      <= 32'h0;
         tl_reg      <= 32'h0;
         systick_reg <= 32'h0;
         pcnt_reg    <= 16'h0;
         en_reg      <= 1'b0;
         ie_reg      <= 1'b0;
         is_reg      <= 1'b0;
         irq_reg     <= 1'b0;
      end else begin
         th_reg      <= th_next;
         tl_reg      <= tl_next;
         systick_reg <= systick_reg + 32'h1;
         pcnt_reg    <= pcnt_next;
         en_reg      <= en_next;
         ie_reg      <= ie_next;
         is_reg      <= is_next;
         irq_reg     <= ie_next & is_next;
      end
   end

   assign IRQ = irq_reg;

   always_comb begin
      ReadData = 32'h0;
      if (MemRd && hit) begin
         case (sel)
            3'd0:    ReadData = th_reg;
            3'd1:    ReadData = tl_reg;
            3'd2:    ReadData = {29'h0, is_reg, ie_reg, en_reg};
            3'd3:    ReadData = {16'h0, pcnt_reg};
            3'd4:    ReadData = systick_reg;
            default: ReadData = 32'h0;
         endcase
      end
   end
endmodule

// File: tb/tb_timer_irq_peripheral.sv
// Directed and randomized bus traffic against two timer instances (prescale 1
// and 4), compared every cycle with a register-level behavioural model.
module tb_timer_irq_peripheral;
   localparam logic [31:0] BASE = 32'h40000000;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        MemRd = 1'b0;
   logic        MemWr = 1'b0;
   logic [31:0] Addr = 32'h0;
   logic [31:0] WriteData = 32'h0;
   logic [31:0] rd1, rd4;
   logic        irq1, irq4;

   int tests = 0;
   int fails = 0;

   timer_irq_peripheral #(.ADDR_BASE(BASE), .PRESCALE(1)) dut1 (
      .clk(clk), .reset(reset), .MemRd(MemRd), .MemWr(MemWr), .Addr(Addr),
      .WriteData(WriteData), .ReadData(rd1), .IRQ(irq1));

   timer_irq_peripheral #(.ADDR_BASE(BASE), .PRESCALE(4)) dut4 (
      .clk(clk), .reset(reset), .MemRd(MemRd), .MemWr(MemWr), .Addr(Addr),
      .WriteData(WriteData), .ReadData(rd4), .IRQ(irq4));

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Model state, index 0 = prescale 1, index 1 = prescale 4
   int          m_p[2] = '{1, 4};
   logic [31:0] m_th[2], m_tl[2], m_sys[2];
   int          m_pcnt[2];
   bit          m_en[2], m_ie[2], m_is[2], m_irq[2];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         m_th[k] = 0; m_tl[k] = 0; m_sys[k] = 0; m_pcnt[k] = 0;
         m_en[k] = 0; m_ie[k] = 0; m_is[k] = 0; m_irq[k] = 0;
      end
   endtask

   function automatic int word_index();
      logic [31:0] off;
      off = Addr - BASE;
      return (off < 32'd24) ? int'(off >> 2) : -1;
   endfunction

   function automatic logic [31:0] m_read(input int k);
      int w;
      w = word_index();
      if (!MemRd || w < 0) return 32'h0;
      case (w)
         0: return m_th[k];
         1: return m_tl[k];
         2: return {29'h0, m_is[k], m_ie[k], m_en[k]};
         3: return 32'(m_pcnt[k]);
         4: return m_sys[k];
         default: return 32'h0;
      endcase
   endfunction

   task automatic model_edge();
      int w;
      bit wth, wtl, wtc, tick, ovf;
      logic [32:0] sum;
      w = MemWr ? word_index() : -1;
      wth = (w == 0); wtl = (w == 1); wtc = (w == 2);
      for (int k = 0; k < 2; k++) begin
         if (reset) continue;
         tick = m_en[k] && (m_pcnt[k] + 1 == m_p[k]);
         sum  = {1'b0, m_tl[k]} + 33'd1;
         ovf  = tick && !wtl && sum[32];
         if (wtc && !WriteData[0]) m_pcnt[k] = 0;
         else if (m_en[k])         m_pcnt[k] = (m_pcnt[k] + 1) % m_p[k];
         m_is[k] = (wtc ? WriteData[2] : m_is[k]) | (ovf & m_ie[k]);
         if (wtl)       m_tl[k] = WriteData;
         else if (ovf)  m_tl[k] = m_th[k];
         else if (tick) m_tl[k] = sum[31:0];
         if (wth) m_th[k] = WriteData;
         if (wtc) begin
            m_en[k] = WriteData[0];
            m_ie[k] = WriteData[1];
         end
         m_irq[k] = m_ie[k] & m_is[k];
         m_sys[k] = m_sys[k] + 1;
      end
   endtask

   task automatic cycle(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] d);
      MemRd = rd; MemWr = wr; Addr = a; WriteData = d;
      #1;
      chk($sformatf("rdata1 a=%h", a), rd1, m_read(0));
      chk($sformatf("rdata4 a=%h", a), rd4, m_read(1));
      $display("[TB] rd=%0d wr=%0d addr=%h wd=%h rdata1=%h rdata4=%h", rd, wr, a, d, rd1, rd4);
      @(posedge clk);
      model_edge();
      #1;
      chk("irq1", {31'h0, irq1}, {31'h0, m_irq[0]});
      chk("irq4", {31'h0, irq4}, {31'h0, m_irq[1]});
      MemRd = 1'b0; MemWr = 1'b0;
   endtask

   task automatic bw(input logic [31:0] off, input logic [31:0] d);
      cycle(1'b0, 1'b1, BASE + off, d);
   endtask

   task automatic br(input logic [31:0] off);
      cycle(1'b1, 1'b0, BASE + off, 32'h0);
   endtask

   initial begin
      logic [31:0] a, d;
      int r;
      model_reset();
      @(posedge clk); #1;
      br(32'h04); br(32'h10);
      reset = 1'b0;
      br(32'h10); br(32'h10);

      // Reset mid-count
      bw(32'h04, 32'd5); bw(32'h08, 32'h1);
      br(32'h04); br(32'h04); br(32'h0C);
      reset = 1'b1;
      #1;
      model_reset();
      chk("irq1_async_rst", {31'h0, irq1}, 32'h0);
      MemRd = 1'b1; Addr = BASE + 32'h04; #1;
      chk("tl_async_rst", rd1, 32'h0);
      for (int i = 0; i < 5; i++) br(32'(i * 4));
      reset = 1'b0;
      br(32'h10); br(32'h10); br(32'h10);

      // Basic count and overflow on the prescale-1 instance
      bw(32'h00, 32'hFFFFFFFC); bw(32'h04, 32'hFFFFFFFC); bw(32'h08, 32'h3);
      for (int i = 0; i < 4; i++) br(32'h04);
      chk("irq1_on_ovf", {31'h0, irq1}, 32'h1);
      bw(32'h08, 32'h3);
      chk("irq1_cleared", {31'h0, irq1}, 32'h0);
      br(32'h08); br(32'h04);
      bw(32'h08, 32'h3);
      chk("irq1_ovf_beats_clear", {31'h0, irq1}, 32'h1);
      br(32'h08);

      // Masked overflow, then forced pending interrupt
      bw(32'h08, 32'h1);
      for (int i = 0; i < 5; i++) br((i % 2 == 0) ? 32'h08 : 32'h04);
      chk("irq1_masked", {31'h0, irq1}, 32'h0);
      bw(32'h08, 32'h7);
      chk("irq1_forced", {31'h0, irq1}, 32'h1);

      // Prescaler on the prescale-4 instance
      bw(32'h08, 32'h0); bw(32'h04, 32'h0); bw(32'h08, 32'h1);
      for (int i = 0; i < 12; i++) br((i % 2 == 0) ? 32'h0C : 32'h04);
      MemRd = 1'b1; Addr = BASE + 32'h04; #1;
      chk("tl4_after_12", rd4, 32'd3);
      br(32'h0C);
      bw(32'h08, 32'h0);
      br(32'h04); br(32'h0C); br(32'h04); br(32'h0C);

      // Bus decode corners
      br(32'h10); br(32'h14); br(32'h18); br(32'h1C);
      cycle(1'b0, 1'b1, BASE + 32'h20, 32'hDEADBEEF);
      cycle(1'b0, 1'b1, BASE + 32'h10, 32'h12345678);
      br(32'h00); br(32'h04); br(32'h10);
      cycle(1'b0, 1'b0, BASE + 32'h04, 32'h0);
      cycle(1'b1, 1'b0, BASE + 32'h05, 32'h0);
      cycle(1'b1, 1'b1, BASE + 32'h04, 32'hA5A5A5A5);
      br(32'h04);
      cycle(1'b1, 1'b0, 32'h00000004, 32'h0);

      // Randomized traffic, biased towards near-overflow values
      for (int i = 0; i < 400; i++) begin
         r = $urandom_range(0, 9);
         if (r < 8)       a = BASE + 32'(r * 4) + 32'($urandom_range(0, 3));
         else if (r == 8) a = BASE + 32'h20 + 32'($urandom_range(0, 31));
         else             a = $urandom;
         d = ($urandom_range(0, 2) == 0) ? 32'hFFFFFFF8 + 32'($urandom_range(0, 7)) : $urandom;
         cycle(1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0), a, d);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
